// File: rtl/pe_acc.sv
// pe_acc: per-lane accumulator and output stage for the PE multiplier array.
//
// Sums a programmable number of product beats (acc_len, 0 treated as 1) per
// lane into ACC_W-bit wrapping accumulators.  At the end of each group the
// sums are saturated according to Data_type and presented on a valid/ready
// output.  acc_len and Data_type are latched on the first beat of a group.
//
// Optional feature macro: PE_ACC_OUTBUF_EN
//   undefined : result is held in OUT; no beats accepted until it drains.
//   defined   : result moves to a separate output register, the FSM returns
//               straight to IDLE, and accumulation continues while the
//               previous result waits.
//
// Ports:
//   clk          clock, rising edge
//   rst          synchronous reset, active low
//   Data_type    saturation mode (00: 8-bit, 01: 16-bit, 1x: none)
//   acc_len      beats per group
//   in_vld       product beat valid
//   in_rdy       block can accept a beat
//   mul_out_dat  product beat, lane i = [i*IN_W +: IN_W], signed
//   out_vld      result valid
//   out_rdy      downstream accepts the result
//   out_dat      results, lane i = [i*ACC_W +: ACC_W], signed
//   busy         group in progress or result pending
//
// state | meaning
// IDLE  | waiting for the first beat of a group
// ACC   | accumulating beats 2..len
// OUT   | result presented, waiting for out_rdy (unbuffered build only)

module pe_acc #(
    parameter int LANES = 16,
    parameter int IN_W  = 20,
    parameter int ACC_W = 32,
    parameter int CNT_W = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               Data_type,
    input  logic [CNT_W-1:0]         acc_len,
    input  logic                     in_vld,
    output logic                     in_rdy,
    input  logic [LANES*IN_W-1:0]    mul_out_dat,
    output logic                     out_vld,
    input  logic                     out_rdy,
    output logic [LANES*ACC_W-1:0]   out_dat,
    output logic                     busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam logic signed [ACC_W-1:0] S8_MAX  = ACC_W'(127);
    localparam logic signed [ACC_W-1:0] S8_MIN  = -ACC_W'(128);
    localparam logic signed [ACC_W-1:0] S16_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] S16_MIN = -ACC_W'(32768);

    state_t state;
    state_t state_nxt;

    logic [CNT_W-1:0]       cnt;
    logic [CNT_W-1:0]       len_l;
    logic [CNT_W-1:0]       len_in;
    logic [1:0]             dt_l;
    logic [1:0]             dt_use;
    logic [LANES*ACC_W-1:0] acc;
    logic [LANES*ACC_W-1:0] sum_nxt;
    logic [LANES*ACC_W-1:0] sat_nxt;
    logic [LANES*ACC_W-1:0] res;
    logic                   accept;
    logic                   last_beat;
`ifdef PE_ACC_OUTBUF_EN
    logic                   res_vld;
`endif

    function automatic logic [ACC_W-1:0] saturate(input logic signed [ACC_W-1:0] v,
                                                  input logic [1:0] dt);
        logic [ACC_W-1:0] r;
        r = v;
        case (dt)
            2'b00: begin
                if (v > S8_MAX)       r = S8_MAX;
                else if (v < S8_MIN)  r = S8_MIN;
            end
            2'b01: begin
                if (v > S16_MAX)      r = S16_MAX;
                else if (v < S16_MIN) r = S16_MIN;
            end
            default: r = v;
        endcase
        return r;
    endfunction

    assign len_in = (acc_len == '0) ? CNT_W'(1) : acc_len;
    // The first beat of a group uses the live settings; later beats the latched ones.
    assign dt_use = (state == IDLE) ? Data_type : dt_l;
    assign accept = in_vld && in_rdy;

    always_comb begin
        last_beat = 1'b0;
        case (state)
            IDLE:    last_beat = (len_in == CNT_W'(1));
            ACC:     last_beat = (cnt == len_l - CNT_W'(1));
            default: last_beat = 1'b0;
        endcase
    end

    always_comb begin
        sum_nxt = '0;
        sat_nxt = '0;
        for (int i = 0; i < LANES; i++) begin
            logic [ACC_W-1:0] base;
            logic [ACC_W-1:0] ext;
            base = (state == IDLE) ? '0 : acc[i*ACC_W +: ACC_W];
            ext  = {{(ACC_W-IN_W){mul_out_dat[i*IN_W+IN_W-1]}}, mul_out_dat[i*IN_W +: IN_W]};
            sum_nxt[i*ACC_W +: ACC_W] = base + ext;
            sat_nxt[i*ACC_W +: ACC_W] = saturate(sum_nxt[i*ACC_W +: ACC_W], dt_use);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_rdy    = 1'b0;
        out_vld   = 1'b0;
        busy      = 1'b0;
`ifdef PE_ACC_OUTBUF_EN
        // Only a completing beat needs the output register free; the term is
        // combinational on out_rdy so a drain and a load can share a cycle.
        in_rdy  = rst && !(last_beat && res_vld && !out_rdy);
        out_vld = res_vld;
        busy    = (state != IDLE) || res_vld;
        case (state)
            IDLE:    if (accept) state_nxt = last_beat ? IDLE : ACC;
            ACC:     if (accept && last_beat) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`else
        in_rdy  = rst && (state != OUT);
        out_vld = (state == OUT);
        busy    = (state != IDLE);
        case (state)
            IDLE:    if (accept) state_nxt = last_beat ? OUT : ACC;
            ACC:     if (accept && last_beat) state_nxt = OUT;
            OUT:     if (out_rdy) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc   <= '0;
            cnt   <= '0;
            len_l <= '0;
            dt_l  <= '0;
            res   <= '0;
`ifdef PE_ACC_OUTBUF_EN
            res_vld <= 1'b0;
`endif
        end else begin
            if (accept) begin
                acc <= sum_nxt;
                if (state == IDLE) begin
                    cnt   <= CNT_W'(1);
                    len_l <= len_in;
                    dt_l  <= Data_type;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
                if (last_beat) res <= sat_nxt;
            end
`ifdef PE_ACC_OUTBUF_EN
            if (accept && last_beat) res_vld <= 1'b1;
            else if (out_rdy)        res_vld <= 1'b0;
`endif
        end
    end

    assign out_dat = res;

endmodule

// File: tb/tb_pe_acc.sv
module tb_pe_acc;

    localparam int L  = 16;
    localparam int IW = 20;
    localparam int AW = 32;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [1:0]      Data_type = 2'b00;
    logic [CW-1:0]   acc_len = '0;
    logic            in_vld = 1'b0;
    logic            in_rdy;
    logic [L*IW-1:0] mul_out_dat = '0;
    logic            out_vld;
    logic            out_rdy = 1'b0;
    logic [L*AW-1:0] out_dat;
    logic            busy;

    int checks = 0;
    int passes = 0;
    bit rand_rdy = 1'b0;

    logic [L*AW-1:0] exp_q[$];

    pe_acc #(.LANES(L), .IN_W(IW), .ACC_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .Data_type(Data_type), .acc_len(acc_len),
        .in_vld(in_vld), .in_rdy(in_rdy), .mul_out_dat(mul_out_dat),
        .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rand_rdy) #1 out_rdy = ($urandom_range(0, 3) != 0);

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act === expv) passes++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    endtask

    function automatic logic [31:0] tsat(input int v, input logic [1:0] dt);
        if (dt == 2'b00) return (v > 127) ? 127 : (v < -128) ? -128 : v;
        if (dt == 2'b01) return (v > 32767) ? 32767 : (v < -32768) ? -32768 : v;
        return v;
    endfunction

    function automatic logic [L*IW-1:0] fill(input logic [IW-1:0] v);
        logic [L*IW-1:0] r;
        for (int i = 0; i < L; i++) r[i*IW +: IW] = v;
        return r;
    endfunction

    // Reference model and scoreboard: sampled mid-cycle, so a handshake seen
    // here completes on the following rising edge.
    int          m_cnt = 0;
    int          m_len = 1;
    logic [1:0]  m_dt = 2'b00;
    int          m_sum[L];
    bit          hold_v = 1'b0;
    logic [L*AW-1:0] held;

    always @(negedge clk) begin
        if (!rst) begin
            exp_q.delete();
            m_cnt  = 0;
            hold_v = 1'b0;
        end else begin
            if (hold_v && out_vld) begin
                checks++;
                if (out_dat === held) passes++;
                else $display("FAIL out_dat_stable: got %0h expected %0h", out_dat[63:0], held[63:0]);
            end
            hold_v = out_vld && !out_rdy;
            held   = out_dat;
            if (out_vld && out_rdy) begin
                checks++;
                if (exp_q.size() == 0) begin
                    $display("FAIL unexpected_result: got out_vld=1 lane0=%0h expected no result", out_dat[AW-1:0]);
                end else begin
                    logic [L*AW-1:0] e;
                    int bad;
                    e = exp_q.pop_front();
                    bad = -1;
                    for (int i = L - 1; i >= 0; i--)
                        if (out_dat[i*AW +: AW] !== e[i*AW +: AW]) bad = i;
                    if (bad < 0) passes++;
                    else $display("FAIL result_lane%0d: got %0h expected %0h", bad,
                                  out_dat[bad*AW +: AW], e[bad*AW +: AW]);
                end
            end
            if (in_vld && in_rdy) begin
                if (m_cnt == 0) begin
                    m_len = (acc_len == 0) ? 1 : int'(acc_len);
                    m_dt  = Data_type;
                    for (int i = 0; i < L; i++) m_sum[i] = 0;
                end
                for (int i = 0; i < L; i++) begin
                    logic signed [IW-1:0] p;
                    p = mul_out_dat[i*IW +: IW];
                    m_sum[i] = m_sum[i] + int'(p);
                end
                m_cnt++;
                if (m_cnt == m_len) begin
                    logic [L*AW-1:0] e;
                    for (int i = 0; i < L; i++) e[i*AW +: AW] = tsat(m_sum[i], m_dt);
                    exp_q.push_back(e);
                    m_cnt = 0;
                end
            end
        end
    end

    // Called and returning at 1 time unit after a rising edge.
    task automatic send(input logic [CW-1:0] len, input logic [1:0] dt, input logic [L*IW-1:0] d);
        int t;
        t = 0;
        acc_len = len; Data_type = dt; mul_out_dat = d; in_vld = 1'b1;
        forever begin
            @(negedge clk);
            if (in_rdy) break;
            t++;
            if (t > 200) begin
                chk("send_timeout", 1, 0);
                break;
            end
        end
        @(posedge clk); #1;
        in_vld = 1'b0;
    endtask

    task automatic settle();
        int t;
        out_rdy = 1'b1;
        t = 0;
        while ((out_vld || busy) && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 200) chk("settle_timeout", 1, 0);
        @(posedge clk); #1;
    endtask

    initial begin
        logic [L*IW-1:0] d;
        logic [L*AW-1:0] frozen;

        // reset state
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_rdy", in_rdy, 0);
        chk("rst_out_vld", out_vld, 0);
        chk("rst_busy", busy, 0);
        chk("rst_out_dat", out_dat[63:0], 0);
        @(posedge clk); #1;
        rst = 1'b1;
        out_rdy = 1'b1;
        @(negedge clk);
        chk("idle_in_rdy", in_rdy, 1);
        @(posedge clk); #1;

        // basic sum
        for (int b = 0; b < 4; b++) send(4, 2'b10, fill(20'd1000));
        @(negedge clk);
        chk("basic_vld", out_vld, 1);
        chk("basic_lane0", out_dat[0 +: AW], 4000);
        chk("basic_lane15", out_dat[15*AW +: AW], 4000);
        @(negedge clk);
        chk("basic_vld_drop", out_vld, 0);
        settle();

        // 8-bit saturation
        d = '0;
        d[0 +: IW] = 20'd100; d[IW +: IW] = -20'sd100; d[2*IW +: IW] = 20'd5;
        for (int b = 0; b < 3; b++) send(3, 2'b00, d);
        @(negedge clk);
        chk("sat8_lane0", out_dat[0 +: AW], 127);
        chk("sat8_lane1", out_dat[AW +: AW], 32'hFFFFFF80);
        chk("sat8_lane2", out_dat[2*AW +: AW], 15);
        settle();

        // 16-bit saturation
        d = '0;
        d[0 +: IW] = 20'h7FFFF;
        for (int b = 0; b < 2; b++) send(2, 2'b01, d);
        @(negedge clk);
        chk("sat16_lane0", out_dat[0 +: AW], 32767);
        settle();

        // length 0 treated as 1
        d = '0;
        d[0 +: IW] = 20'hFFFFF;
        send(0, 2'b10, d);
        @(negedge clk);
        chk("len0_vld", out_vld, 1);
        chk("len0_lane0", out_dat[0 +: AW], 32'hFFFFFFFF);
        settle();

        // backpressure
        out_rdy = 1'b0;
        send(2, 2'b10, fill(20'd3));
        send(2, 2'b10, fill(20'd4));
        acc_len = 2; Data_type = 2'b10; mul_out_dat = fill(20'd11); in_vld = 1'b1;
        @(negedge clk);
        frozen = out_dat;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
`ifdef PE_ACC_OUTBUF_EN
            chk("bp_in_rdy", in_rdy, (k == 0) ? 1 : 0);
`else
            chk("bp_in_rdy", in_rdy, 0);
`endif
            chk("bp_out_dat", out_dat[63:0], frozen[63:0]);
            @(posedge clk); #1;
`ifdef PE_ACC_OUTBUF_EN
            if (k == 0) mul_out_dat = fill(20'd12);
`endif
        end
        out_rdy = 1'b1;
`ifndef PE_ACC_OUTBUF_EN
        send(2, 2'b10, fill(20'd11));
`endif
        send(2, 2'b10, fill(20'd12));
        settle();

        // reset mid-group
        send(4, 2'b10, fill(20'd7));
        send(4, 2'b10, fill(20'd7));
        rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", busy, 0);
        chk("midrst_out_vld", out_vld, 0);
        chk("midrst_out_dat", out_dat[63:0], 0);
        @(posedge clk); #1;
        for (int b = 0; b < 4; b++) send(4, 2'b10, fill(20'd1));
        @(negedge clk);
        chk("midrst_lane0", out_dat[0 +: AW], 4);
        settle();

        // mid-group setting changes ignored
        d = '0;
        d[0 +: IW] = 20'd100;
        send(3, 2'b00, d);
        @(negedge clk);
        chk("chg_no_vld1", out_vld, 0);
        @(posedge clk); #1;
        send(1, 2'b10, d);
        @(negedge clk);
        chk("chg_no_vld2", out_vld, 0);
        @(posedge clk); #1;
        send(1, 2'b10, d);
        @(negedge clk);
        chk("chg_vld", out_vld, 1);
        chk("chg_lane0", out_dat[0 +: AW], 127);
        settle();

        // randomized groups with random backpressure
        rand_rdy = 1'b1;
        for (int g = 0; g < 60; g++) begin
            int len;
            int nb;
            len = $urandom_range(0, 5);
            nb  = (len == 0) ? 1 : len;
            for (int b = 0; b < nb; b++) begin
                for (int i = 0; i < L; i++) d[i*IW +: IW] = IW'($urandom);
                if (b == 0) send(CW'(len), 2'($urandom_range(0, 3)), d);
                else        send(CW'($urandom_range(0, 6)), 2'($urandom_range(0, 3)), d);
                if ($urandom_range(0, 3) == 0) begin
                    repeat ($urandom_range(1, 2)) @(posedge clk);
                    #1;
                end
            end
        end
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        settle();
        chk("queue_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
